// File: rtl/riscv_pkg.sv
// Shared types for the register-file writeback path.
// Combinational only: no state and no latency.
// No flow control: types and constants only.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  // One buffered writeback: destination register plus result
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Round-robin pointer: which source wins when both have work
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

  function automatic rr_t rr_flip(input rr_t r);
    return (r == RR_A) ? RR_B : RR_A;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head is visible combinationally on dout.
// A push at edge N makes the entry visible on dout right after edge N.
// full blocks further pushes; no same-cycle pop credit is offered to the writer.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer tells a full FIFO apart from an empty one
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO regardless of stored contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges ALU and load/MC writebacks onto the single RF write port with a pending-write scoreboard.
// Entry accepted at edge N drives we3/a3/wd3 after edge N+1; the RF captures one edge later.
// Each source sees ready = !full of its own FIFO; round-robin prevents either source starving.
module rf_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]   b_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              we3,
  output logic [REG_AW-1:0] a3,
  output logic [XLEN-1:0]   wd3
);

  wb_entry_t        a_dout;
  wb_entry_t        b_dout;
  logic             a_full, a_empty, b_full, b_empty;
  logic             a_push, b_push;
  logic             pop_a, pop_b;
  rr_t              rr;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  // Writes to x0 complete the handshake but are discarded here
  assign a_ready = !a_full;
  assign b_ready = !b_full;
  assign a_push  = a_valid && a_ready && (a_rd != '0);
  assign b_push  = b_valid && b_ready && (b_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (a_push),
    .din   ({a_rd, a_data}),
    .pop   (pop_a),
    .dout  (a_dout),
    .full  (a_full),
    .empty (a_empty)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (b_push),
    .din   ({b_rd, b_data}),
    .pop   (pop_b),
    .dout  (b_dout),
    .full  (b_full),
    .empty (b_empty)
  );

  // Grant: a lone non-empty source always wins; a tie goes to the rr pointer
  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (!a_empty && !b_empty) begin
      if (rr == RR_A) pop_a = 1'b1;
      else            pop_b = 1'b1;
    end else begin
      pop_a = !a_empty;
      pop_b = !b_empty;
    end
  end

  // rr only moves on contention, handing the next tie to the loser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr <= RR_B;
    else if (!a_empty && !b_empty) rr <= rr_flip(rr);
  end

  // Registered write port; address/data hold when idle, enable pulses once per entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= pop_a || pop_b;
      if (pop_a) begin
        a3  <= a_dout.rd;
        wd3 <= a_dout.data;
      end else if (pop_b) begin
        a3  <= b_dout.rd;
        wd3 <= b_dout.data;
      end
    end
  end

  // Scoreboard update: clear on the RF write cycle, a same-cycle issue re-sets the bit
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && (iss_rd != '0)) set_vec[iss_rd] = 1'b1;
    if (we3) clr_vec[a3] = 1'b1;
    pending_nxt = ((pending & ~clr_vec) | set_vec) & ~{{(NREGS-1){1'b0}}, 1'b1};
  end

  // Pending-write state; bit 0 never sets so x0 always reads as free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // The write-cycle register is still busy: the RF holds stale data until that edge
  assign q_busy1 = pending[q_rs1];
  assign q_busy2 = pending[q_rs2];

  // Issuing to an already-pending register is an issue-stage bug, except on its clearing cycle
  a_no_double_issue: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_valid && (iss_rd != '0) && pending[iss_rd] && !(we3 && (a3 == iss_rd))));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, iss_rd, q_rs1, q_rs2, a3;
  logic [31:0] a_data, b_data, wd3;
  logic        q_busy1, q_busy2, we3;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  bit   sb_ignore = 1'b0;
  bit   a_full_seen = 1'b0;

  rf_wb_arbiter #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [4:0] rd, input logic [31:0] d);
    bit acc = 1'b0;
    int n = 0;
    a_valid = 1'b1; a_rd = rd; a_data = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = a_ready;
      @(posedge clk);
      #1;
      n++;
    end
    a_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL a_send_timeout: got no handshake for rd=%0d, required handshake", rd);
    end
  endtask

  task automatic send_b(input logic [4:0] rd, input logic [31:0] d);
    bit acc = 1'b0;
    int n = 0;
    b_valid = 1'b1; b_rd = rd; b_data = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = b_ready;
      @(posedge clk);
      #1;
      n++;
    end
    b_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL b_send_timeout: got no handshake for rd=%0d, required handshake", rd);
    end
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
    align();
    iss_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every RF write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && !sb_ignore) begin
      if (!a_ready) a_full_seen = 1'b1;
      if (we3) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got a3=%0d wd3=%0h, required no write", a3, wd3);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_a3", {27'd0, a3}, {27'd0, e.rd});
          chk("wb_wd3", wd3, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    q_rs1 = '0; q_rs2 = '0;

    // Reset state
    #12;
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_a3", {27'd0, a3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_busy1", 32'(q_busy1), 32'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);

    // Single A write: visible one cycle after acceptance, for one cycle only
    align();
    exp_push(5'd1, 32'd42);
    send_a(5'd1, 32'd42);
    @(negedge clk);
    chk("single_we3_not_yet", 32'(we3), 32'd0);
    @(negedge clk);
    chk("single_we3", 32'(we3), 32'd1);
    chk("single_a3", {27'd0, a3}, 32'd1);
    chk("single_wd3", wd3, 32'd42);
    @(negedge clk);
    chk("single_we3_one_cycle", 32'(we3), 32'd0);
    chk("single_a3_hold", {27'd0, a3}, 32'd1);
    drain();

    // Dual sustained traffic from idle: B first, then strict alternation
    align();
    exp_push(5'd3, 32'd9);  exp_push(5'd2, 32'd7);
    exp_push(5'd13, 32'h13); exp_push(5'd12, 32'h12);
    exp_push(5'd15, 32'h15); exp_push(5'd14, 32'h14);
    exp_push(5'd17, 32'h17); exp_push(5'd16, 32'h16);
    fork
      begin
        send_a(5'd2, 32'd7); send_a(5'd12, 32'h12);
        send_a(5'd14, 32'h14); send_a(5'd16, 32'h16);
      end
      begin
        send_b(5'd3, 32'd9); send_b(5'd13, 32'h13);
        send_b(5'd15, 32'h15); send_b(5'd17, 32'h17);
      end
    join
    drain();

    // Write to x0: handshake completes, no RF write, x0 never busy
    align();
    send_a(5'd0, 32'd99);
    q_rs1 = 5'd0;
    repeat (4) begin
      @(negedge clk);
      chk("x0_no_we3", 32'(we3), 32'd0);
    end
    chk("x0_busy1", 32'(q_busy1), 32'd0);

    // Reset mid-burst drops queued entries and pending bits
    align();
    issue(5'd9);
    q_rs2 = 5'd9;
    @(negedge clk);
    chk("pre_rst_busy2", 32'(q_busy2), 32'd1);
    align();
    sb_ignore = 1'b1;
    fork
      begin
        send_a(5'd20, 32'h20); send_a(5'd21, 32'h21);
        send_a(5'd22, 32'h22); send_a(5'd23, 32'h23);
      end
      begin
        send_b(5'd24, 32'h24); send_b(5'd25, 32'h25);
        send_b(5'd26, 32'h26); send_b(5'd27, 32'h27);
      end
      begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_we3", 32'(we3), 32'd0);
        chk("midrst_a3", {27'd0, a3}, 32'd0);
        chk("midrst_wd3", wd3, 32'd0);
        chk("midrst_busy2", 32'(q_busy2), 32'd0);
      end
    join
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    sb_ignore = 1'b0;
    @(negedge clk);
    chk("postrst_a_ready", 32'(a_ready), 32'd1);
    chk("postrst_b_ready", 32'(b_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("postrst_no_we3", 32'(we3), 32'd0);

    // A fills behind a saturating B; nothing lost, A stays in order
    align();
    a_full_seen = 1'b0;
    exp_push(5'd16, 32'hB0); exp_push(5'd8, 32'hA0);
    exp_push(5'd17, 32'hB1); exp_push(5'd9, 32'hA1);
    exp_push(5'd18, 32'hB2); exp_push(5'd10, 32'hA2);
    exp_push(5'd19, 32'hB3); exp_push(5'd11, 32'hA3);
    exp_push(5'd20, 32'hB4); exp_push(5'd21, 32'hB5);
    fork
      begin
        send_a(5'd8, 32'hA0); send_a(5'd9, 32'hA1);
        send_a(5'd10, 32'hA2); send_a(5'd11, 32'hA3);
      end
      begin
        send_b(5'd16, 32'hB0); send_b(5'd17, 32'hB1); send_b(5'd18, 32'hB2);
        send_b(5'd19, 32'hB3); send_b(5'd20, 32'hB4); send_b(5'd21, 32'hB5);
      end
    join
    drain();
    chk("a_ready_went_low", 32'(a_full_seen), 32'd1);

    // Scoreboard: busy from issue until the cycle after the matching write
    align();
    q_rs1 = 5'd5; q_rs2 = 5'd5;
    @(negedge clk);
    chk("sb_idle_busy1", 32'(q_busy1), 32'd0);
    align();
    issue(5'd5);
    @(negedge clk);
    chk("sb_issued_busy1", 32'(q_busy1), 32'd1);
    chk("sb_issued_busy2", 32'(q_busy2), 32'd1);
    repeat (3) @(negedge clk);
    chk("sb_held_busy1", 32'(q_busy1), 32'd1);
    align();
    exp_push(5'd5, 32'h55);
    send_a(5'd5, 32'h55);
    @(negedge clk);
    chk("sb_pre_write_busy1", 32'(q_busy1), 32'd1);
    @(negedge clk);
    chk("sb_write_cycle_we3", 32'(we3), 32'd1);
    chk("sb_write_cycle_busy1", 32'(q_busy1), 32'd1);
    @(negedge clk);
    chk("sb_cleared_busy1", 32'(q_busy1), 32'd0);

    // Set and clear on the same register in the same cycle: set wins
    align();
    issue(5'd5);
    exp_push(5'd5, 32'h66);
    send_a(5'd5, 32'h66);
    align();
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    chk("sb_setclr_we3", 32'(we3), 32'd1);
    align();
    iss_valid = 1'b0;
    @(negedge clk);
    chk("sb_setclr_busy1", 32'(q_busy1), 32'd1);
    repeat (2) @(negedge clk);
    chk("sb_setclr_busy1_held", 32'(q_busy1), 32'd1);
    align();
    exp_push(5'd5, 32'h77);
    send_a(5'd5, 32'h77);
    repeat (3) @(negedge clk);
    chk("sb_final_clear_busy1", 32'(q_busy1), 32'd0);

    // x0 query stays free even when x0 is issued
    align();
    q_rs1 = 5'd0;
    issue(5'd0);
    @(negedge clk);
    chk("sb_x0_busy1", 32'(q_busy1), 32'd0);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
